dsp_op_sequencer: RTL and testbench
===================================

Name: dsp_op_sequencer

Overview:
Command-side controller for the DSP48A1-style slice (`Main_DSP`). It drives operands, opmode, carry-in, clock-enable and reset into the slice. It waits out the slice's fixed pipeline latency, then captures P and CARRYOUT and returns them as a response. Upstream logic sees a clean valid/ready command/response pair and never deals with slice pipeline timing.

Parameters:
- LATENCY, 4: rising edges from operand launch to valid P at the slice output. Legal range 1..15.
- OPMODE_RST, 8'h00: value driven on dsp_opmode after reset.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_a  in  18  operand A.
- cmd_b  in  18  operand B.
- cmd_c  in  48  operand C.
- cmd_d  in  18  operand D.
- cmd_opmode  in  8  slice opmode.
- cmd_carryin  in  1  carry-in.
- clear  in  1  request a one-cycle slice register reset.
- dsp_a  out  18  to slice A.
- dsp_b  out  18  to slice B.
- dsp_c  out  48  to slice C.
- dsp_d  out  18  to slice D.
- dsp_opmode  out  8  to slice OPMODE.
- dsp_carryin  out  1  to slice CARRYIN.
- dsp_ce  out  1  fanned out to all slice CE* inputs.
- dsp_rst  out  1  fanned out to all slice RST* inputs.
- dsp_p  in  48  from slice P.
- dsp_carryout  in  1  from slice CARRYOUT.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_p  out  48  captured P.
- rsp_carryout  out  1  captured CARRYOUT.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (RST=1, asynchronous) drives the following values:
  - state IDLE, cycle counter 0.
  - dsp_a/b/c/d = 0, dsp_carryin = 0, dsp_opmode = OPMODE_RST.
  - dsp_ce = 0, dsp_rst = 1 while RST is high. dsp_rst deasserts on the first edge after RST falls.
  - rsp_valid = 0, rsp_p = 0, rsp_carryout = 0, cmd_ready = 0, busy = 0.
- All outputs are registered. cmd_ready is the only exception: it is combinational and equals (state==IDLE && !clear).
- States are IDLE, CLR, RUN and RESP.
- IDLE, with clear=1 → CLR:
  - dsp_rst = 1 for exactly one cycle, dsp_ce = 0.
  - clear has priority over cmd_valid; no command is accepted on that edge.
  - CLR → IDLE unconditionally.
- IDLE, on an edge with cmd_valid && cmd_ready:
  - Register all cmd_* fields onto dsp_*.
  - dsp_ce = 1, counter = LATENCY-1, go to RUN.
- RUN:
  - dsp_* operands and dsp_opmode are held stable; dsp_ce = 1.
  - Counter decrements each edge.
  - On the edge where the counter is 0, capture dsp_p → rsp_p and dsp_carryout → rsp_carryout. Set rsp_valid = 1, dsp_ce = 0, go to RESP.
  - Net timing: capture happens on the LATENCY-th edge after the accept edge.
- RESP:
  - dsp_ce = 0, so the slice P register is frozen.
  - rsp_* are held until rsp_valid && rsp_ready on an edge; then rsp_valid = 0 and state goes to IDLE.
  - The earliest next accept is the following edge, so throughput is one command per LATENCY+2 cycles.
- Feedback opmodes (X or Z mux selecting P): the result is the slice output after LATENCY enabled edges with inputs held stable. No special handling; the bench model must match this definition.
- cmd_* values are don't-care except on the accept edge. clear is ignored outside IDLE.
- RST asserted mid-RUN or mid-RESP:
  - Any pending response is discarded and rsp_valid drops immediately.
  - The slice is reset through dsp_rst.
  - No response is ever produced for the aborted command.
- rsp_ready held high in IDLE or RUN has no effect.

Optional Feature:
DSP_SEQ_CHECK_EN
- When defined, the block gains these ports:
  - cmd_exp_p (in, 48): expected P, latched on accept.
  - rsp_err (out, 1): valid with rsp_valid; equals (captured P != latched expected P).
  - err_count (out, 16): counts responses with rsp_err=1 at response handshake. It saturates at 16'hFFFF and is cleared by RST only.
- When not defined, these ports and their registers do not exist, and all other behaviour is identical.

Test Plan:
- Reset, then cmd A=18'hA7, B=18'hB7, C=48'hC7, D=18'hD7, opmode=8'h1D, carryin=0, with the slice at LATENCY=4 → dsp_ce high for 4 cycles; rsp_valid on edge 4 after accept with rsp_p=48'h10469, rsp_carryout=0; cmd_ready=0 until the response handshake.
- Response backpressure: hold rsp_ready=0 for 10 cycles → rsp_p stays 48'h10469, dsp_ce=0 throughout, cmd_valid held high is not accepted; rsp_ready=1 → IDLE next edge, new command accepted on the following edge.
- clear and cmd_valid asserted together in IDLE → dsp_rst high exactly one cycle, no accept; command accepted 2 edges later; slice P reads 0 before the new result.
- Assert RST 2 cycles into RUN → rsp_valid stays 0, dsp_rst=1, dsp_ce=0, outputs at reset values; after release, the next command completes normally with no stale response.
- cmd A=18'h3FFFF, B=18'hB, D=18'hD, opmode=8'h13 → rsp_p=48'hDFFFFC0018.
- With DSP_SEQ_CHECK_EN:
  - cmd_exp_p=48'h10469 on the first case → rsp_err=0.
  - cmd_exp_p=48'h10468 → rsp_err=1 and err_count increments to 1.

Source files
------------

// File: rtl/dsp_op_sequencer.sv
// Valid/ready command sequencer for a pipelined DSP48A1-style slice.
// Define DSP_SEQ_CHECK_EN to add expected-P checking and an error counter.
`timescale 1ns/1ps
module dsp_op_sequencer #(
   parameter int unsigned LATENCY    = 4,
   parameter logic [7:0]  OPMODE_RST = 8'h00
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [17:0] cmd_a,
   input  logic [17:0] cmd_b,
   input  logic [47:0] cmd_c,
   input  logic [17:0] cmd_d,
   input  logic [7:0]  cmd_opmode,
   input  logic        cmd_carryin,
`ifdef DSP_SEQ_CHECK_EN
   input  logic [47:0] cmd_exp_p,
   output logic        rsp_err,
   output logic [15:0] err_count,
`endif
   input  logic        clear,
   output logic [17:0] dsp_a,
   output logic [17:0] dsp_b,
   output logic [47:0] dsp_c,
   output logic [17:0] dsp_d,
   output logic [7:0]  dsp_opmode,
   output logic        dsp_carryin,
   output logic        dsp_ce,
   output logic        dsp_rst,
   input  logic [47:0] dsp_p,
   input  logic        dsp_carryout,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [47:0] rsp_p,
   output logic        rsp_carryout,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CLR, RUN, RESP} state_t;

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   state_t     state;
   logic [3:0] cnt;

`ifdef DSP_SEQ_CHECK_EN
   logic [47:0] exp_q;
`endif

   // Ready is held low while RST is asserted so reset reads as not-ready.
   assign cmd_ready = (state == IDLE) && !clear && !RST;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state        <= IDLE;
         cnt          <= '0;
         dsp_a        <= '0;
         dsp_b        <= '0;
         dsp_c        <= '0;
         dsp_d        <= '0;
         dsp_opmode   <= OPMODE_RST;
         dsp_carryin  <= 1'b0;
         dsp_ce       <= 1'b0;
         dsp_rst      <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_p        <= '0;
         rsp_carryout <= 1'b0;
         busy         <= 1'b0;
`ifdef DSP_SEQ_CHECK_EN
         exp_q        <= '0;
         rsp_err      <= 1'b0;
         err_count    <= '0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               dsp_rst <= clear;
               if (clear) begin
                  state  <= CLR;
                  dsp_ce <= 1'b0;
                  busy   <= 1'b1;
               end else if (cmd_valid) begin
                  dsp_a       <= cmd_a;
                  dsp_b       <= cmd_b;
                  dsp_c       <= cmd_c;
                  dsp_d       <= cmd_d;
                  dsp_opmode  <= cmd_opmode;
                  dsp_carryin <= cmd_carryin;
                  dsp_ce      <= 1'b1;
                  cnt         <= CNT_INIT;
                  state       <= RUN;
                  busy        <= 1'b1;
`ifdef DSP_SEQ_CHECK_EN
                  exp_q       <= cmd_exp_p;
`endif
               end
            end
            CLR: begin
               dsp_rst <= 1'b0;
               state   <= IDLE;
               busy    <= 1'b0;
            end
            RUN: begin
               if (cnt == 4'd0) begin
                  rsp_p        <= dsp_p;
                  rsp_carryout <= dsp_carryout;
                  rsp_valid    <= 1'b1;
                  dsp_ce       <= 1'b0;
                  state        <= RESP;
`ifdef DSP_SEQ_CHECK_EN
                  rsp_err      <= (dsp_p != exp_q);
`endif
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
                  busy      <= 1'b0;
`ifdef DSP_SEQ_CHECK_EN
                  if (rsp_err && err_count != 16'hFFFF)
                     err_count <= err_count + 16'd1;
`endif
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_op_sequencer.sv
// Bench for dsp_op_sequencer: behavioural slice stub, vector table,
// hand-written corner sequences and randomized commands.
`timescale 1ns/1ps
module tb_dsp_op_sequencer;

   localparam int L = 4;

   typedef struct {
      logic [17:0] a;
      logic [17:0] b;
      logic [47:0] c;
      logic [17:0] d;
      logic [7:0]  op;
      logic        cin;
      logic [47:0] p;
      logic        co;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid, cmd_ready;
   logic [17:0] cmd_a, cmd_b, cmd_d;
   logic [47:0] cmd_c;
   logic [7:0]  cmd_opmode;
   logic        cmd_carryin, clear;
   logic [17:0] dsp_a, dsp_b, dsp_d;
   logic [47:0] dsp_c, dsp_p;
   logic [7:0]  dsp_opmode;
   logic        dsp_carryin, dsp_ce, dsp_rst, dsp_carryout;
   logic        rsp_valid, rsp_ready, rsp_carryout, busy;
   logic [47:0] rsp_p;
`ifdef DSP_SEQ_CHECK_EN
   logic [47:0] cmd_exp_p;
   logic        rsp_err;
   logic [15:0] err_count;
`endif

   int errors = 0;
   int checks = 0;
   int exp_errs = 0;
   vec_t vt[8];

   always #5 clk = ~clk;

   dsp_op_sequencer #(.LATENCY(L), .OPMODE_RST(8'h5A)) dut (
      .CLK(clk), .RST(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_d(cmd_d),
      .cmd_opmode(cmd_opmode), .cmd_carryin(cmd_carryin),
`ifdef DSP_SEQ_CHECK_EN
      .cmd_exp_p(cmd_exp_p), .rsp_err(rsp_err), .err_count(err_count),
`endif
      .clear(clear),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_c(dsp_c), .dsp_d(dsp_d),
      .dsp_opmode(dsp_opmode), .dsp_carryin(dsp_carryin),
      .dsp_ce(dsp_ce), .dsp_rst(dsp_rst),
      .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_p(rsp_p), .rsp_carryout(rsp_carryout), .busy(busy)
   );

   // Arithmetic of the slice: pre-adder, signed multiply, X/Z muxes, post-adder.
   function automatic logic [48:0] slice_f(
      input logic [17:0] a, input logic [17:0] b, input logic [47:0] c,
      input logic [17:0] d, input logic [7:0] op, input logic cin,
      input logic [47:0] p);
      logic [17:0] b1;
      logic signed [35:0] m;
      logic [47:0] x, z;
      b1 = op[4] ? (op[6] ? d - b : d + b) : b;
      m = $signed(a) * $signed(b1);
      case (op[1:0])
         2'd0: x = '0;
         2'd1: x = {{12{m[35]}}, m};
         2'd2: x = p;
         default: x = {d[11:0], a, b1};
      endcase
      case (op[3:2])
         2'd2: z = p;
         2'd3: z = c;
         default: z = '0;
      endcase
      if (op[7]) slice_f = {1'b0, z} - ({1'b0, x} + 49'(cin));
      else slice_f = {1'b0, z} + {1'b0, x} + 49'(cin);
   endfunction

   // Slice stub: LATENCY-1 enabled register stages, synchronous reset.
   logic [48:0] pipe [L-1];
   always @(posedge clk) begin
      if (dsp_rst) begin
         for (int i = 0; i < L-1; i++) pipe[i] <= '0;
      end else if (dsp_ce) begin
         pipe[0] <= slice_f(dsp_a, dsp_b, dsp_c, dsp_d, dsp_opmode,
                            dsp_carryin, dsp_p);
         for (int i = 1; i < L-1; i++) pipe[i] <= pipe[i-1];
      end
   end
   assign dsp_p = pipe[L-2][47:0];
   assign dsp_carryout = pipe[L-2][48];

   function automatic vec_t mk(
      input logic [17:0] a, input logic [17:0] b, input logic [47:0] c,
      input logic [17:0] d, input logic [7:0] op, input logic cin,
      input logic [47:0] p, input logic co);
      vec_t v;
      v.a = a; v.b = b; v.c = c; v.d = d;
      v.op = op; v.cin = cin; v.p = p; v.co = co;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v, input bit bad);
      cmd_a = v.a; cmd_b = v.b; cmd_c = v.c; cmd_d = v.d;
      cmd_opmode = v.op; cmd_carryin = v.cin;
      cmd_valid = 1'b1;
`ifdef DSP_SEQ_CHECK_EN
      cmd_exp_p = bad ? (v.p ^ 48'h1) : v.p;
`else
      if (bad) cmd_carryin = v.cin;
`endif
   endtask

   task automatic accept();
      int n = 0;
      while (!cmd_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      chk("accept_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("ce_after_accept", dsp_ce, 1);
   endtask

   task automatic finish(input vec_t v, input int hold, input bit bad);
      int n = 0;
      do begin
         @(posedge clk); #1; n++;
         if (!rsp_valid) begin
            chk("run_ce", dsp_ce, 1);
            chk("run_ready", cmd_ready, 0);
         end
      end while (!rsp_valid && n < 40);
      chk("latency", n, L);
      chk("rsp_p", rsp_p, v.p);
      chk("rsp_co", rsp_carryout, v.co);
      chk("resp_ce", dsp_ce, 0);
`ifdef DSP_SEQ_CHECK_EN
      chk("rsp_err", rsp_err, bad);
`endif
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_p", rsp_p, v.p);
         chk("hold_valid", rsp_valid, 1);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("rsp_drop", rsp_valid, 0);
      chk("idle_busy", busy, 0);
`ifdef DSP_SEQ_CHECK_EN
      if (bad) exp_errs++;
      chk("err_count", err_count, exp_errs);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int n, stale;
      vt[0] = mk(18'hA7, 18'hB7, 48'hC7, 18'hD7, 8'h1D, 0, 48'h10469, 0);
      vt[1] = mk(18'h3FFFF, 18'hB, 48'h0, 18'hD, 8'h13, 0, 48'hDFFFFC0018, 0);
      vt[2] = mk(18'h2, 18'h3, 48'h10, 18'h0, 8'h0D, 1, 48'h17, 0);
      vt[3] = mk(18'h2, 18'h3, 48'h100, 18'h0, 8'h8D, 0, 48'hFA, 0);
      vt[4] = mk(18'h0, 18'h1, 48'hFFFFFFFFFFFF, 18'h0, 8'h0F, 0, 48'h0, 1);
      vt[5] = mk(18'h3FFFF, 18'h2, 48'h0, 18'h0, 8'h0D, 0, 48'hFFFFFFFFFFFE, 0);
      vt[6] = mk(18'h5, 18'h5, 48'h5, 18'h5, 8'h00, 0, 48'h0, 0);
      vt[7] = mk(18'h3, 18'h2, 48'h1, 18'h7, 8'h5D, 1, 48'h11, 0);

      rst = 1'b1; cmd_valid = 0; clear = 0; rsp_ready = 0;
      cmd_a = 0; cmd_b = 0; cmd_c = 0; cmd_d = 0;
      cmd_opmode = 0; cmd_carryin = 0;
`ifdef DSP_SEQ_CHECK_EN
      cmd_exp_p = 0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", rsp_valid, 0);
      chk("rst_p", rsp_p, 0);
      chk("rst_co", rsp_carryout, 0);
      chk("rst_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dsp_rst", dsp_rst, 1);
      chk("rst_ce", dsp_ce, 0);
      chk("rst_opmode", dsp_opmode, 8'h5A);
      chk("rst_a", dsp_a, 0);
      chk("rst_c", dsp_c, 0);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rel_dsp_rst", dsp_rst, 0);
      chk("rel_ready", cmd_ready, 1);

      for (int i = 0; i < 8; i++) begin
         drive(vt[i], 0); accept(); finish(vt[i], i % 3, 0);
      end
`ifdef DSP_SEQ_CHECK_EN
      drive(vt[0], 0); accept(); finish(vt[0], 0, 0);
      drive(vt[0], 1); accept(); finish(vt[0], 0, 1);
`endif

      // Backpressure with a waiting command.
      drive(vt[0], 0); accept();
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      drive(vt[2], 0);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_p", rsp_p, 48'h10469);
         chk("bp_ce", dsp_ce, 0);
         chk("bp_ready", cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("bp_drop", rsp_valid, 0);
      chk("bp_idle_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("bp_accept_busy", busy, 1);
      chk("bp_accept_a", dsp_a, 18'h2);
      finish(vt[2], 0, 0);

      // Clear has priority over a simultaneous command.
      drive(vt[5], 0); clear = 1'b1;
      @(posedge clk); #1;
      clear = 1'b0;
      chk("clr_dsp_rst", dsp_rst, 1);
      chk("clr_ce", dsp_ce, 0);
      chk("clr_ready", cmd_ready, 0);
      chk("clr_busy", busy, 1);
      @(posedge clk); #1;
      chk("clr_dsp_rst_off", dsp_rst, 0);
      chk("clr_slice_p", dsp_p, 0);
      chk("clr_idle_ready", cmd_ready, 1);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("clr_accept_ce", dsp_ce, 1);
      chk("clr_p_still0", dsp_p, 0);
      finish(vt[5], 1, 0);

      // Reset two cycles into RUN.
      drive(vt[0], 0); accept();
      @(posedge clk); #1;
      rst = 1'b1; #1;
      exp_errs = 0;
      chk("mr_valid", rsp_valid, 0);
      chk("mr_dsp_rst", dsp_rst, 1);
      chk("mr_ce", dsp_ce, 0);
      chk("mr_busy", busy, 0);
      chk("mr_a", dsp_a, 0);
      chk("mr_opmode", dsp_opmode, 8'h5A);
      @(posedge clk); #1;
      chk("mr_slice_p", dsp_p, 0);
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) stale++;
      end
      chk("mr_no_stale", stale, 0);
      drive(vt[7], 0); accept(); finish(vt[7], 0, 0);

      // Reset while a response is pending.
      drive(vt[3], 0); accept();
      n = 0;
      while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("mq_pending", rsp_valid, 1);
      rst = 1'b1; #1;
      exp_errs = 0;
      chk("mq_valid", rsp_valid, 0);
      chk("mq_p", rsp_p, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      stale = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (rsp_valid) stale++;
      end
      chk("mq_no_stale", stale, 0);
      drive(vt[4], 0); accept(); finish(vt[4], 0, 0);

      // Randomized non-feedback commands against the arithmetic model.
      for (int k = 0; k < 40; k++) begin
         logic [48:0] r;
         int xs;
         v.a = 18'($urandom); v.b = 18'($urandom);
         v.d = 18'($urandom);
         v.c = 48'({$urandom(), $urandom()});
         v.cin = 1'($urandom);
         v.op = 8'($urandom);
         xs = $urandom_range(0, 2);
         v.op[1:0] = (xs == 2) ? 2'd3 : 2'(xs);
         v.op[3:2] = $urandom_range(0, 1) ? 2'd3 : 2'd0;
         r = slice_f(v.a, v.b, v.c, v.d, v.op, v.cin, 48'h0);
         v.p = r[47:0]; v.co = r[48];
         drive(v, 0); accept(); finish(v, $urandom_range(0, 3), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
